ps2_receiver: RTL and testbench

PS/2 keyboard receive front end sitting between the board `kbd` pins and the CPU's memory-mapped keyboard peripheral in `top`. It synchronizes the PS/2 clock/data pair, deframes 11-bit device-to-host frames, checks odd parity and the stop bit, and queues good bytes in a small first-word-fall-through FIFO. The CPU side drains the FIFO through a valid/read handshake and sees sticky error flags.

---
 rtl/ps2_receiver.sv | 223 ++++++++++++++++++++++
 tb/tb_ps2_receiver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ps2_receiver
// Brief    : PS/2 device-to-host receiver. Synchronizes the PS/2 clock/data
//            pair, deframes 11-bit frames (start, 8 data LSB first, odd
//            parity, stop), queues good bytes in a first-word-fall-through
//            FIFO and reports sticky parity / framing / overflow errors.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_receiver #(
    parameter int FIFO_DEPTH     = 4,      // power of 2, >= 2
    parameter int TIMEOUT_CYCLES = 50000   // mid-frame inactivity limit, >= 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    kbd,        // [0] PS/2 clock, [1] PS/2 data
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [7:0]                    data_out,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [AW:0]   c_DEPTH = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] c_TMAX  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Synchronizer and edge detector state
    // ------------------------------------------------------------------------
    logic r_clk_s1;
    logic r_clk_s2;
    logic r_clk_prev;
    logic r_dat_s1;
    logic r_dat_s2;

    // ------------------------------------------------------------------------
    // Deframer state
    // ------------------------------------------------------------------------
    state_t       r_state;
    logic [2:0]   r_bitcnt;
    logic [7:0]   r_shift;
    logic         r_parity;
    logic [TW-1:0] r_tcnt;

    // ------------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------------
    logic [7:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]  r_count;

    // ------------------------------------------------------------------------
    // Sticky flags
    // ------------------------------------------------------------------------
    logic r_perr;
    logic r_ferr;
    logic r_ovf;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic w_fall;
    logic w_bit;
    logic w_timeout;
    logic w_stop_fall;
    logic w_par_ok;
    logic w_good;
    logic w_set_perr;
    logic w_set_ferr;
    logic w_pop;
    logic w_full;
    logic w_accept;
    logic w_set_ovf;

    // Falling PS/2 clock edge on the synchronized line; data sampled alongside.
    assign w_fall = r_clk_prev & ~r_clk_s2;
    assign w_bit  = r_dat_s2;

    // Timeout only fires on a cycle without an edge, so a late-but-arriving
    // edge is still honoured.
    assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_tcnt == c_TMAX);

    // Frame evaluation happens on the stop-bit edge itself.
    assign w_stop_fall = (r_state == ST_STOP) && w_fall;
    assign w_par_ok    = ^{r_shift, r_parity};
    assign w_good      = w_stop_fall && w_bit && w_par_ok;
    assign w_set_perr  = w_stop_fall && w_bit && !w_par_ok;
    assign w_set_ferr  = (w_stop_fall && !w_bit) || w_timeout;

    // A pop frees a slot on the same edge, so a full FIFO still accepts.
    assign w_pop     = rd_en && (r_count != '0);
    assign w_full    = (r_count == c_DEPTH);
    assign w_accept  = w_good && (!w_full || w_pop);
    assign w_set_ovf = w_good && w_full && !w_pop;

    // Two-flop synchronizers plus the previous-clock register; idle level is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= kbd[0];
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= kbd[1];
            r_dat_s2   <= r_dat_s1;
        end
    end

    // Inactivity counter: held at zero while idle and restarted by each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if (w_fall || (r_state == ST_IDLE) || w_timeout) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    // Frame deframer: start bit, eight data bits LSB first, parity, stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_parity <= 1'b0;
        end else if (w_timeout) begin
            r_state  <= ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    // A high level on the edge is not a start bit; stay put.
                    if (!w_bit) begin
                        r_state  <= ST_DATA;
                        r_bitcnt <= 3'd0;
                    end
                end
                ST_DATA: begin
                    r_shift  <= {w_bit, r_shift[7:1]};
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        r_state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    r_parity <= w_bit;
                    r_state  <= ST_STOP;
                end
                ST_STOP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Circular FIFO with wrapping pointers and an explicit occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_mem[r_wptr] <= r_shift;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_perr <= (r_perr & ~err_clr) | w_set_perr;
            r_ferr <= (r_ferr & ~err_clr) | w_set_ferr;
            r_ovf  <= (r_ovf  & ~err_clr) | w_set_ovf;
        end
    end

    assign data_out   = r_mem[r_rptr];
    assign valid      = (r_count != '0);
    assign count      = r_count;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_receiver
// Brief    : Self-checking bench for ps2_receiver. Frames are driven on the
//            PS/2 pins; a queue-based reference model predicts FIFO contents
//            and flags; a monitor compares every popped byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_receiver;

    localparam int DEPTH = 4;
    localparam int TMO   = 2000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] kbd;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] data_out;
    logic       valid;
    logic [2:0] count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    ps2_receiver #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .kbd        (kbd),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
        .data_out   (data_out),
        .valid      (valid),
        .count      (count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: bytes the FIFO should hold, in order, plus flags.
    logic [7:0] exp_q [$];
    bit         e_perr;
    bit         e_ferr;
    bit         e_ovf;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: rd_en seen with valid means the head is popped on the next edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rd_en && valid) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 32'(data_out), 32'hFFFF_FFFF);
                end else begin
                    chk("pop_data", 32'(data_out), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(exp_q.size()));
        chk({tag, "_valid"}, 32'(valid), 32'(exp_q.size() != 0));
        chk({tag, "_perr"},  32'(parity_err), 32'(e_perr));
        chk({tag, "_ferr"},  32'(frame_err),  32'(e_ferr));
        chk({tag, "_ovf"},   32'(overflow),   32'(e_ovf));
        if (exp_q.size() != 0) begin
            chk({tag, "_head"}, 32'(data_out), 32'(exp_q[0]));
        end
    endtask

    // Drive the first n bits of an 11-bit frame (bit 0 = start). Optionally
    // raise rd_en so the pop lands on the same edge as the stop-bit push.
    task automatic send_raw(input logic [10:0] f, input int n, input int hp, input bit pop_at_stop);
        for (int i = 0; i < n; i++) begin
            kbd[1] = f[i];
            repeat (hp) @(negedge clk);
            kbd[0] = 1'b0;
            if (pop_at_stop && i == 10) begin
                repeat (2) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                repeat (hp - 3) @(negedge clk);
            end else begin
                repeat (hp) @(negedge clk);
            end
            kbd[0] = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit par, input bit stop,
                             input int hp, input bit pop_at_stop, input string tag);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        send_raw(f, 11, hp, pop_at_stop);
        repeat (4) @(negedge clk);
        if (!stop) begin
            e_ferr = 1'b1;
        end else if (((^d) ^ par) != 1'b1) begin
            e_perr = 1'b1;
        end else if (exp_q.size() >= DEPTH) begin
            e_ovf = 1'b1;
        end else begin
            exp_q.push_back(d);
        end
        check_state(tag);
    endtask

    task automatic pulse_rd();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 2 * DEPTH + 2 && valid; k++) begin
            pulse_rd();
        end
        chk({tag, "_drained_q"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_drained_cnt"}, 32'(count), 32'd0);
    endtask

    task automatic clear_err(input string tag);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        e_perr = 1'b0;
        e_ferr = 1'b0;
        e_ovf  = 1'b0;
        @(negedge clk);
        check_state(tag);
    endtask

    function automatic bit odd_par(input logic [7:0] d);
        return ~(^d);
    endfunction

    initial begin
        kbd     = 2'b11;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        rst_n   = 1'b0;
        e_perr  = 1'b0;
        e_ferr  = 1'b0;
        e_ovf   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values while reset is held
        chk("rst_data_out", 32'(data_out), 32'h00);
        chk("rst_valid",    32'(valid),    32'd0);
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_perr",     32'(parity_err), 32'd0);
        chk("rst_ferr",     32'(frame_err),  32'd0);
        chk("rst_ovf",      32'(overflow),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle data line with the PS/2 clock toggling as fast as possible
        repeat (10000) begin
            @(negedge clk);
            kbd[0] = ~kbd[0];
        end
        kbd[0] = 1'b1;
        repeat (4) @(negedge clk);
        check_state("idle");

        // Single frame, then pop
        send_byte(8'h1C, 1'b0, 1'b1, 3, 1'b0, "single");
        pulse_rd();
        check_state("single_pop");

        // Back-to-back frames
        send_byte(8'hF0, 1'b1, 1'b1, 2, 1'b0, "b2b_1");
        send_byte(8'h1C, 1'b0, 1'b1, 2, 1'b0, "b2b_2");
        drain("b2b");

        // Parity error
        send_byte(8'h1C, 1'b1, 1'b1, 3, 1'b0, "parerr");
        clear_err("parerr_clr");

        // Overflow, then a push coinciding with a pop on a full FIFO
        for (int v = 1; v <= 5; v++) begin
            send_byte(8'(v), odd_par(8'(v)), 1'b1, 3, 1'b0, "ovf_fill");
        end
        clear_err("ovf_clr");
        send_byte(8'h06, odd_par(8'h06), 1'b1, 4, 1'b1, "ovf_coinc");
        drain("ovf");

        // Timeout: start plus three data bits, then stall
        send_raw({1'b1, 1'b0, 8'h1C, 1'b0}, 4, 3, 1'b0);
        repeat (TMO + 20) @(negedge clk);
        e_ferr = 1'b1;
        check_state("timeout");
        send_byte(8'h1C, 1'b0, 1'b1, 3, 1'b0, "after_tmo");
        drain("after_tmo");
        clear_err("tmo_clr");

        // Reset asserted mid-frame
        send_raw({1'b1, 1'b0, 8'hA5, 1'b0}, 5, 3, 1'b0);
        rst_n = 1'b0;
        kbd   = 2'b11;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        e_perr = 1'b0;
        e_ferr = 1'b0;
        e_ovf  = 1'b0;
        @(negedge clk);
        check_state("midrst");
        send_byte(8'h1C, 1'b0, 1'b1, 3, 1'b0, "after_rst");
        drain("after_rst");

        // Randomized frames with occasional errors, reads and clears
        for (int n = 0; n < 80; n++) begin
            logic [7:0] d;
            int         kind;
            int         hp;
            int         rds;
            bit         par;
            bit         stop;
            d    = 8'($urandom);
            kind = $urandom_range(0, 9);
            hp   = $urandom_range(2, 5);
            par  = odd_par(d);
            stop = 1'b1;
            if (kind == 0) par  = ~par;
            if (kind == 1) stop = 1'b0;
            send_byte(d, par, stop, hp, 1'b0, "rnd");
            rds = $urandom_range(0, 2);
            for (int r = 0; r < rds; r++) begin
                if (valid) pulse_rd();
            end
            if ($urandom_range(0, 7) == 0) clear_err("rnd_clr");
        end
        drain("rnd");
        clear_err("final_clr");

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
